// File: rtl/dice_roller.sv
// ----------------------------------------------------------------------------
// dice_roller
//
// Parametrised N-die roller. A chain of free-running face counters, wired as
// an odometer, is sampled at a moment set by the user's roll timing. A
// roll/hold handshake runs a fixed-length tumble phase, then latches a stable
// result and raises valid.
//
// Parameters
//   NUM_DICE       number of dice (>= 1)
//   FACES          faces per die (2..15), face values 1..FACES
//   TUMBLE_CYCLES  cycles spent tumbling (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   roll       in   roll request, level-sampled at each edge
//   hold_mask  in   bit i=1 keeps die i's previous result (sampled on accept)
//   dice_out   out  die i at bits [i*W +: W]
//   valid      out  result stable and complete
//   busy       out  tumble in progress
//   sum_out    out  registered sum of latched results (DICE_SUM_EN only)
//
// Configuration macro
//   DICE_SUM_EN  when defined, adds the sum_out port and its adder.
// ----------------------------------------------------------------------------
module dice_roller #(
    parameter int NUM_DICE      = 2,
    parameter int FACES         = 6,
    parameter int TUMBLE_CYCLES = 4,
    localparam int W            = $clog2(FACES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  roll,
    input  logic [NUM_DICE-1:0]   hold_mask,
    output logic [NUM_DICE*W-1:0] dice_out,
    output logic                  valid,
`ifdef DICE_SUM_EN
    output logic                  busy,
    output logic [$clog2(NUM_DICE*FACES+1)-1:0] sum_out
`else
    output logic                  busy
`endif
);

    localparam int TW = (TUMBLE_CYCLES > 1) ? $clog2(TUMBLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        DONE
    } state_t;

    state_t              state_q;
    logic [TW-1:0]       tcnt_q;
    logic [NUM_DICE-1:0] hold_q;
    logic                valid_q;
    logic                busy_q;

    logic [W-1:0] cnt_q [NUM_DICE];
    logic [W-1:0] cnt_d [NUM_DICE];
    logic [W-1:0] res_q [NUM_DICE];
    logic [W-1:0] res_d [NUM_DICE];
    logic         carry;

    // ------------------------------------------------------------------
    // Odometer counters: die 0 steps every edge; die i steps only when
    // every lower die is at FACES, i.e. when die i-1 wraps on this edge.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path leaves it unassigned (no latch).
        carry = 1'b1;
        for (int i = 0; i < NUM_DICE; i++) begin
            cnt_d[i] = cnt_q[i];
            if (carry) begin
                cnt_d[i] = (cnt_q[i] == W'(FACES)) ? W'(1) : cnt_q[i] + W'(1);
            end
            carry = carry && (cnt_q[i] == W'(FACES));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            for (int i = 0; i < NUM_DICE; i++) cnt_q[i] <= W'(1);
        end else begin
            for (int i = 0; i < NUM_DICE; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Value each die takes at the end of the tumble: held dice keep their
    // result, the others capture the live counter as it stands pre-edge.
    always_comb begin
        for (int i = 0; i < NUM_DICE; i++) begin
            res_d[i] = hold_q[i] ? res_q[i] : cnt_q[i];
        end
    end

`ifdef DICE_SUM_EN
    localparam int SW = $clog2(NUM_DICE*FACES + 1);
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            sum_d = sum_d + SW'(res_d[i]);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Roll handshake FSM with registered valid/busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            // NOTE: the result registers are reset because they are shown
            // on dice_out straight out of reset and must read as face 1.
            for (int i = 0; i < NUM_DICE; i++) res_q[i] <= W'(1);
`ifdef DICE_SUM_EN
            sum_q   <= SW'(NUM_DICE);
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (roll) begin
                        state_q <= ROLLING;
                        tcnt_q  <= TW'(TUMBLE_CYCLES - 1);
                        hold_q  <= hold_mask;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ROLLING: begin
                    // roll is deliberately ignored while tumbling.
                    if (tcnt_q != '0) begin
                        tcnt_q <= tcnt_q - TW'(1);
                    end else begin
                        for (int i = 0; i < NUM_DICE; i++) res_q[i] <= res_d[i];
`ifdef DICE_SUM_EN
                        sum_q   <= sum_d;
`endif
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While tumbling, non-held dice animate with the live counters; all
    // sources are registers, so there is no input-to-output path.
    always_comb begin
        dice_out = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            dice_out[i*W +: W] = (state_q == ROLLING && !hold_q[i]) ? cnt_q[i] : res_q[i];
        end
    end

    assign valid = valid_q;
    assign busy  = busy_q;
`ifdef DICE_SUM_EN
    assign sum_out = sum_q;
`endif

endmodule

// File: tb/tb_dice_roller.sv
// ----------------------------------------------------------------------------
// tb_dice_roller
//
// Randomised bench for dice_roller. The reference model treats the odometer
// as a mixed-radix number: after n non-reset edges, die i shows
// floor(n / FACES^i) mod FACES + 1. Each accepted roll pushes its expected
// result, sum and completion edge into a scoreboard; a monitor pops and
// compares whenever valid rises. A second instance (3 dice, 4 faces) covers
// the wrap behaviour.
// ----------------------------------------------------------------------------
module tb_dice_roller;

    localparam int ND = 2;
    localparam int F  = 6;
    localparam int T  = 4;
    localparam int W  = 3;

    localparam int WND = 3;
    localparam int WF  = 4;
    localparam int WW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic            rst;
    logic            roll;
    logic [ND-1:0]   hold_mask;
    logic [ND*W-1:0] dice_out;
    logic            valid;
    logic            busy;
`ifdef DICE_SUM_EN
    logic [3:0]      sum_out;
`endif

    // wrap instance
    logic              w_rst;
    logic              w_roll;
    logic [WND-1:0]    w_mask;
    logic [WND*WW-1:0] w_dice;
    logic              w_valid;
    logic              w_busy;
`ifdef DICE_SUM_EN
    logic [3:0]        w_sum;
`endif

    dice_roller #(.NUM_DICE(ND), .FACES(F), .TUMBLE_CYCLES(T)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .roll     (roll),
        .hold_mask(hold_mask),
        .dice_out (dice_out),
        .valid    (valid),
`ifdef DICE_SUM_EN
        .sum_out  (sum_out),
`endif
        .busy     (busy)
    );

    dice_roller #(.NUM_DICE(WND), .FACES(WF), .TUMBLE_CYCLES(T)) u_wrap (
        .clk      (clk),
        .rst      (w_rst),
        .roll     (w_roll),
        .hold_mask(w_mask),
        .dice_out (w_dice),
        .valid    (w_valid),
`ifdef DICE_SUM_EN
        .sum_out  (w_sum),
`endif
        .busy     (w_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Face shown by die i after n edges of an odometer with f faces.
    function automatic int digit(input int i, input int n, input int f);
        int m = n;
        for (int j = 0; j < i; j++) m = m / f;
        return (m % f) + 1;
    endfunction

    typedef struct {
        logic [ND*W-1:0] dice;
        int              sum;
        int              edge_n;
    } exp_t;

    exp_t sb[$];

    // edge bookkeeping shared by stimulus and monitor
    int   n_edges  = 0;
    logic last_rst = 1'b1;
    int   w_edges  = 0;
    always @(posedge clk) begin
        last_rst <= rst;
        n_edges  <= rst ? 0 : n_edges + 1;
        w_edges  <= w_rst ? 0 : w_edges + 1;
    end

    int              model_res[ND];
    logic [ND-1:0]   cur_hold   = '0;
    logic [ND*W-1:0] shown      = '0;
    int              busy_run   = 0;
    logic            prev_valid = 1'b0;
    bit              w_done     = 1'b0;

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (last_rst) begin
            check("rst_dice", dice_out, 6'b001_001);
            check("rst_valid", valid, 0);
            check("rst_busy", busy, 0);
`ifdef DICE_SUM_EN
            check("rst_sum", sum_out, ND);
`endif
            shown      = 6'b001_001;
            busy_run   = 0;
            prev_valid = 1'b0;
        end else begin
            for (int i = 0; i < ND; i++) begin
                check("die_range", (dice_out[i*W +: W] >= 1 && dice_out[i*W +: W] <= F), 1);
            end
            check("valid_busy_excl", valid && busy, 0);
            if (valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result_dice", dice_out, e.dice);
                    check("result_edge", n_edges, e.edge_n);
                    check("busy_len", busy_run, T);
`ifdef DICE_SUM_EN
                    check("result_sum", sum_out, e.sum);
`endif
                    shown = e.dice;
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
                for (int i = 0; i < ND; i++) begin
                    if (cur_hold[i])
                        check("held_die", dice_out[i*W +: W], shown[i*W +: W]);
                    else
                        check("live_die", dice_out[i*W +: W], digit(i, n_edges, F));
                end
            end else begin
                check("idle_dice", dice_out, shown);
            end
            prev_valid = valid;
        end
    end

    // Issue a roll: expected result is the live value just before the
    // latch edge k+T, i.e. the odometer after k+T-1 edges.
    task automatic do_roll(input logic [ND-1:0] mask, input bit keep);
        exp_t e;
        int   k;
        int   s;
        cur_hold  = mask;
        hold_mask = mask;
        roll      = 1'b1;
        k         = n_edges + 1;
        s         = 0;
        e.dice    = '0;
        for (int i = 0; i < ND; i++) begin
            if (!mask[i]) model_res[i] = digit(i, k + T - 1, F);
            e.dice[i*W +: W] = W'(model_res[i]);
            s += model_res[i];
        end
        e.sum    = s;
        e.edge_n = k + T;
        sb.push_back(e);
        tick();
        if (!keep) roll = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [ND-1:0] m;
        rst       = 1'b1;
        roll      = 1'b0;
        hold_mask = '0;
        for (int i = 0; i < ND; i++) model_res[i] = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();

        // basic roll accepted on the 3rd non-reset edge
        do_roll(2'b00, 1'b0);
        tick();
        tick();
        check("basic_busy_mid", busy, 1);
        tick();
        check("basic_valid_early", valid, 0);
        tick();
        check("basic_valid", valid, 1);
        check("basic_dice", dice_out, {3'd2, 3'd1});
`ifdef DICE_SUM_EN
        check("basic_sum", sum_out, 3);
`endif

        // hold die 1
        do_roll(2'b10, 1'b0);
        repeat (T) tick();
        check("hold_die1", dice_out[W +: W], 2);

        // roll pulse during the tumble is ignored
        do_roll(2'b00, 1'b0);
        tick();
        roll = 1'b1;
        tick();
        roll = 1'b0;
        tick();
        check("ignored_valid_early", valid, 0);
        tick();
        check("ignored_valid", valid, 1);

        // random gaps and masks, including all-held rolls
        repeat (12) begin
            repeat ($urandom_range(0, 3)) tick();
            m = ND'($urandom_range(0, 3));
            do_roll(m, 1'b0);
            repeat (T) tick();
        end

        // roll held high: back-to-back acceptance
        m = ND'($urandom_range(0, 3));
        repeat (3) begin
            do_roll(m, 1'b1);
            repeat (T) tick();
        end
        roll = 1'b0;
        tick();

        // reset while tcnt=1 aborts the roll
        do_roll(2'b00, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < ND; i++) model_res[i] = 1;
        tick();
        rst = 1'b0;
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_dice", dice_out, 6'b001_001);
        tick();
        check("abort_valid_after", valid, 0);

        do_roll(ND'($urandom_range(0, 3)), 1'b0);
        repeat (T + 1) tick();

        for (int i = 0; i < 500 && !w_done; i++) tick();
        check("wrap_done", w_done, 1);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ------------------------------------------------------------------
    // Wrap instance: 3 dice, 4 faces
    // ------------------------------------------------------------------
    initial begin
        w_rst  = 1'b1;
        w_roll = 1'b0;
        w_mask = '0;
        tick();
        tick();
        w_rst = 1'b0;
        while (w_edges < 12) tick();
        w_roll = 1'b1;
        tick();
        w_roll = 1'b0;
        tick();
        tick();
        tick();
        // after 16 edges the odometer reads {1,1,2}
        check("wrap_busy", w_busy, 1);
        check("wrap_live", w_dice, {3'd2, 3'd1, 3'd1});
        tick();
        check("wrap_valid", w_valid, 1);
        check("wrap_result", w_dice, {3'd2, 3'd1, 3'd1});
`ifdef DICE_SUM_EN
        check("wrap_sum", w_sum, 4);
`endif
        repeat (80) begin
            w_roll = 1'($urandom_range(0, 1));
            w_mask = WND'($urandom_range(0, 7));
            tick();
            for (int i = 0; i < WND; i++) begin
                check("wrap_range", (w_dice[i*WW +: WW] >= 1 && w_dice[i*WW +: WW] <= WF), 1);
            end
        end
        w_roll = 1'b0;
        w_done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
